// File: rtl/fft_bist_pkg.sv
// Shared types and constants for the FFT self-test driver.
package fft_bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT,
        READ,
        DRAIN,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        MODE_LFSR    = 2'd0,
        MODE_IMPULSE = 2'd1,
        MODE_DC      = 2'd2
    } mode_e;

    localparam int LOAD_BIT = 0;
    localparam int READ_BIT = 1;
    localparam int IDX_LSB  = 2;

    // 16-bit Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    endfunction

endpackage

// File: rtl/bist_misr.sv
// Byte-wide multiple-input signature register used to compact engine results.
module bist_misr #(
    parameter int                MISR_W    = 16,
    parameter logic [MISR_W-1:0] MISR_POLY = 'h1021
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [7:0]        din,
    output logic [MISR_W-1:0] sig
);

    logic [MISR_W-1:0] sig_q;
    logic [MISR_W-1:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clr) begin
            sig_d = '0;
        end else if (en) begin
            sig_d = {sig_q[MISR_W-2:0], 1'b0}
                  ^ (sig_q[MISR_W-1] ? MISR_POLY : '0)
                  ^ MISR_W'(din);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/fft_bist_driver.sv
// Self-test sequencer: loads generated samples into the FFT engine, waits, reads results, signs them.
// States: IDLE await start | LOAD drive samples | WAIT compute latency | READ strobe results | DRAIN last byte | DONE report
module fft_bist_driver
    import fft_bist_pkg::*;
#(
    parameter int unsigned       N_POINTS    = 4,
    parameter int unsigned       WAIT_CYCLES = 8,
    parameter int                MISR_W      = 16,
    parameter logic [MISR_W-1:0] MISR_POLY   = 16'h1021,
    parameter logic [15:0]       LFSR_SEED   = 16'hACE1,
    parameter logic [7:0]        IMPULSE_VAL = 8'h7F
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [MISR_W-1:0] expected_sig,
    output logic [7:0]        dut_ui_in,
    output logic [7:0]        dut_uio_in,
    input  logic [7:0]        dut_uo_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [MISR_W-1:0] signature
);

    localparam int CNT_W = ($clog2(WAIT_CYCLES) > 6) ? $clog2(WAIT_CYCLES) : 6;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       lfsr_q, lfsr_d;
    mode_e             mode_q, mode_d;
    logic [MISR_W-1:0] sig_q;
    logic              pass_q;
    logic              misr_clr;
    logic              misr_en;
    logic              start_acc;
    logic [MISR_W-1:0] misr_sig;
    logic              sig_match;

    assign sig_match = (misr_sig == expected_sig);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lfsr_d     = lfsr_q;
        mode_d     = mode_q;
        dut_ui_in  = '0;
        dut_uio_in = '0;
        busy       = 1'b1;
        done       = 1'b0;
        misr_clr   = 1'b0;
        misr_en    = 1'b0;
        start_acc  = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    start_acc = 1'b1;
                    misr_clr  = 1'b1;
                    state_d   = LOAD;
                    cnt_d     = '0;
                    lfsr_d    = LFSR_SEED;
                    mode_d    = (mode == 2'd3) ? MODE_LFSR : mode_e'(mode);
                end
            end
            LOAD: begin
                dut_uio_in[LOAD_BIT]     = 1'b1;
                dut_uio_in[7:IDX_LSB]    = cnt_q[5:0];
                case (mode_q)
                    MODE_IMPULSE: dut_ui_in = (cnt_q == '0) ? IMPULSE_VAL : 8'h00;
                    MODE_DC:      dut_ui_in = IMPULSE_VAL;
                    default:      dut_ui_in = lfsr_q[7:0];
                endcase
                lfsr_d = lfsr_step(lfsr_q);
                if (cnt_q == CNT_W'(N_POINTS - 1)) begin
                    state_d = WAIT;
                    cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = READ;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            READ: begin
                dut_uio_in[READ_BIT]  = 1'b1;
                dut_uio_in[7:IDX_LSB] = cnt_q[5:0];
                // Result for strobe j arrives during j+1, so nothing is valid yet at j=0.
                misr_en = (cnt_q != '0);
                if (cnt_q == CNT_W'(2 * N_POINTS - 1)) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DRAIN: begin
                misr_en = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lfsr_q  <= LFSR_SEED;
            mode_q  <= MODE_LFSR;
            sig_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
            mode_q  <= mode_d;
            if (start_acc) begin
                sig_q  <= '0;
                pass_q <= 1'b0;
            end else if (state_q == DONE) begin
                sig_q  <= misr_sig;
                pass_q <= sig_match;
            end
        end
    end

    // Result is visible alongside the done pulse, then held from the captured copy.
    assign signature = (state_q == DONE) ? misr_sig  : sig_q;
    assign pass      = (state_q == DONE) ? sig_match : pass_q;

    bist_misr #(
        .MISR_W   (MISR_W),
        .MISR_POLY(MISR_POLY)
    ) u_misr (
        .clk(clk),
        .rst(rst),
        .clr(misr_clr),
        .en (misr_en),
        .din(dut_uo_out),
        .sig(misr_sig)
    );

endmodule

// File: doc/fft_bist_driver.md
Name: fft_bist_driver

Overview:
Synthesizable self-test driver for the FFT engine. It sits between the chip-level pin interface and the engine's pins, and runs one complete test sequence per start pulse:
- load N_POINTS generated samples;
- wait a fixed compute latency;
- read back 2*N_POINTS result bytes (real and imaginary);
- compact those bytes into a MISR signature and compare it to an expected value.

It generalises the bench-only pin driving into reusable, parametrised RTL with selectable stimulus modes, so the same test runs on silicon and in gate-level simulation.

Parameters:
- N_POINTS, 4, FFT points per run; legal range 1..32.
- WAIT_CYCLES, 8, idle cycles between the load and read phases (engine compute latency); must be ≥1.
- MISR_W, 16, signature width.
- MISR_POLY, 16'h1021, MISR feedback polynomial.
- LFSR_SEED, 16'hACE1, LFSR seed, reloaded at every start.
- IMPULSE_VAL, 8'h7F, amplitude of impulse/DC samples.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a run.
- mode  in  2  stimulus mode: 0 = LFSR random, 1 = impulse, 2 = DC, 3 = reserved (treated as 0).
- expected_sig  in  MISR_W  golden signature, sampled at DONE.
- dut_ui_in  out  8  sample byte to the engine.
- dut_uio_in  out  8  engine control: [0] = load strobe, [1] = read strobe, [7:2] = index.
- dut_uo_out  in  8  engine result byte; valid one cycle after its read strobe.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at the end of a run.
- pass  out  1  comparison result; held until the next accepted start.
- signature  out  MISR_W  final MISR value; held until the next accepted start.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, port rst.
- rst=1 at any clock edge, including mid-run:
  - state = IDLE;
  - all outputs = 0;
  - LFSR = LFSR_SEED, MISR = 0, counters = 0.
- FSM states: IDLE → LOAD → WAIT → READ → DRAIN → DONE → IDLE.
- IDLE:
  - start=1 is accepted; mode is latched, MISR cleared, LFSR reseeded, pass and signature cleared.
  - Next state is LOAD.
- start while busy, or while in DONE, is ignored.
- LOAD: N_POINTS cycles, k = 0..N_POINTS-1.
  - dut_uio_in = {k[5:0], 1'b0, 1'b1}.
  - dut_ui_in by mode: LFSR low byte (LFSR advances each cycle); IMPULSE_VAL when k=0, else 0; IMPULSE_VAL every cycle.
  - LFSR is 16-bit Fibonacci, taps 16,14,13,11.
- WAIT: WAIT_CYCLES cycles with dut_uio_in = 0 and dut_ui_in = 0.
- READ: 2*N_POINTS cycles, j = 0..2N-1.
  - dut_uio_in = {j[5:0], 1'b1, 1'b0}; dut_ui_in = 0.
  - Each byte returned on dut_uo_out (one cycle later) updates the MISR.
- DRAIN: 1 cycle; dut_uio_in = 0; captures the final byte.
- MISR update per byte b:
  - sig_next = {sig[MISR_W-2:0], 1'b0} ^ (sig[MISR_W-1] ? MISR_POLY : 0) ^ zero-extended b.
  - Exactly 2*N_POINTS updates per run: the first uses the byte returned in READ cycle 1, the last the byte returned in DRAIN.
- DONE: 1 cycle.
  - done=1; signature = sig; pass = (sig == expected_sig).
  - Next state is IDLE.
- busy is 1 in LOAD, WAIT, READ, DRAIN and DONE; 0 in IDLE.
- Run length with start accepted at edge 0: N_POINTS + WAIT_CYCLES + 2*N_POINTS + 1 cycles, then the done pulse.
  - Default parameters: done is high in the cycle after edge 21.
- Counters wrap only via the FSM: the index counter is compared against N_POINTS-1 / 2N-1 and reset on each state entry.

Decomposition:
- Package fft_bist_pkg holds:
  - state enum (IDLE, LOAD, WAIT, READ, DRAIN, DONE);
  - mode enum (MODE_LFSR, MODE_IMPULSE, MODE_DC);
  - uio_in bit-position constants (LOAD_BIT = 0, READ_BIT = 1, IDX_LSB = 2).
- One sub-module, bist_misr: clk, rst, clr, en, din[7:0], sig[MISR_W-1:0]; parametrised by MISR_W and MISR_POLY.
- The LFSR stays inline.

Test Plan:
- mode=1, N=4, start pulse → LOAD cycles show dut_ui_in 7F,00,00,00 with dut_uio_in 01,05,09,0D; then 8 cycles of dut_uio_in=00; busy=1 throughout.
- READ phase → dut_uio_in sequence 02,06,0A,0E,12,16,1A,1E; done pulses exactly 22 cycles after the start edge.
- Mock engine returns uo_out=00 always, expected_sig=0000 → signature=0000, pass=1. Same run with expected_sig=0001 → pass=0.
- Mock returns 01 for the first read byte only, else 00 → signature=0080, pass=1 with expected 0080.
- mode=0, two consecutive runs → identical LOAD byte sequences, and the first byte is 8'hE1 (low byte of LFSR_SEED).
- Further protocol checks:
  - start asserted during WAIT → ignored; the run completes on schedule.
  - rst=1 in READ → next cycle busy=0, done=0, dut_uio_in=00, signature=0000.
  - A subsequent start runs normally.
